// File: rtl/uart_tx_mmio_if.sv
// Core data-memory bus signals seen by the memory-mapped UART transmitter.
// The master side is the core; the slave side is the peripheral.
interface uart_tx_mmio_if;
  logic        WRITE;
  logic        READ;
  logic [31:0] ADDRESS;
  logic [31:0] DATA_IN;
  logic [31:0] DATA_OUT;
  logic        SEL;

  modport master (
    output WRITE, READ, ADDRESS, DATA_IN,
    input  DATA_OUT, SEL
  );

  modport slave (
    input  WRITE, READ, ADDRESS, DATA_IN,
    output DATA_OUT, SEL
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a byte FIFO,
// STATUS reports FULL/EMPTY/BUSY/OVERRUN; the FSM serialises FIFO bytes on TX.
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
  input  logic          CLK,
  input  logic          RESET,
  uart_tx_mmio_if.slave bus,
  output logic          TX
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          overrun;

  logic [1:0]    state;
  logic [7:0]    shift;
  logic [2:0]    bitcnt;
  logic [BW-1:0] baud;
  logic          tx_q;

  logic dec_tx;
  logic dec_st;
  logic full;
  logic empty;
  logic busy;
  logic push_req;
  logic accept;
  logic pop;
  logic bit_end;
  logic [31:0] status;
  logic unused_data_bits;

  assign dec_tx   = (bus.ADDRESS == BASE_ADDR);
  assign dec_st   = (bus.ADDRESS == BASE_ADDR + 32'd4);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign pop      = (state == IDLE) && !empty;
  assign push_req = bus.WRITE && dec_tx;
  // A full FIFO still takes the byte when the FSM frees a slot on the same edge.
  assign accept   = push_req && (!full || pop);
  assign bit_end  = (baud == BW'(CLKS_PER_BIT - 1));

  assign status   = {28'd0, overrun, busy, empty, full};

  always_comb begin
    bus.SEL      = bus.READ && (dec_tx || dec_st);
    bus.DATA_OUT = '0;
    if (bus.READ && dec_st)
      bus.DATA_OUT = status;
  end

  assign unused_data_bits = ^bus.DATA_IN[31:8];

  always_ff @(posedge CLK) begin
    if (accept)
      mem[wptr] <= bus.DATA_IN[7:0];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && !accept)
        overrun <= 1'b1;
      else if (bus.WRITE && dec_st && bus.DATA_IN[3])
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      tx_q   <= 1'b1;
      shift  <= '0;
      bitcnt <= '0;
      baud   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            shift  <= mem[rptr];
            bitcnt <= '0;
            baud   <= '0;
            tx_q   <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud  <= '0;
            tx_q  <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bitcnt == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              shift  <= shift >> 1;
              tx_q   <= shift[1];
              bitcnt <= bitcnt + 3'd1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud  <= '0;
            tx_q  <= 1'b1;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign TX = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: stimulus queues expected frames and load
// responses; independent monitors decode TX and check every load cycle.
module tb_uart_tx_mmio;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] STAT  = 32'h0000_1004;

  logic CLK;
  logic RESET;
  logic TX;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .BASE_ADDR    (BASE)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave),
    .TX    (TX)
  );

  typedef struct {
    logic [7:0] data;
    int         gap;
  } frame_t;

  typedef struct {
    logic [31:0] addr;
    logic        sel;
    logic [31:0] data;
  } rd_t;

  frame_t txq[$];
  rd_t    rq[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_busy = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr_hold(input logic [31:0] addr, input logic [31:0] data);
    bus.WRITE   = 1'b1;
    bus.ADDRESS = addr;
    bus.DATA_IN = data;
    step();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    wr_hold(addr, data);
    bus.WRITE = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic sel, input logic [31:0] data);
    rd_t r;
    r.addr = addr;
    r.sel  = sel;
    r.data = data;
    rq.push_back(r);
    bus.READ    = 1'b1;
    bus.ADDRESS = addr;
    step();
    bus.READ = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] data, input int gap);
    frame_t f;
    f.data = data;
    f.gap  = gap;
    txq.push_back(f);
  endtask

  task automatic wait_done(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (txq.size() == 0 && !mon_busy) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check("drain_timeout", {31'd0, done}, 32'd1);
  endtask

  // Load monitor: every cycle with READ high must match the next queued response.
  initial begin
    rd_t r;
    forever begin
      @(negedge CLK);
      if (bus.READ && !RESET) begin
        if (rq.size() == 0) begin
          check("unexpected_read", 32'd1, 32'd0);
        end else begin
          r = rq.pop_front();
          check($sformatf("sel@%h", r.addr), {31'd0, bus.SEL}, {31'd0, r.sel});
          check($sformatf("data_out@%h", r.addr), bus.DATA_OUT, r.data);
        end
      end
    end
  end

  // TX monitor: one sample per cycle; a frame is 10 bits of CPB samples each.
  initial begin
    logic       smp [10*CPB];
    logic [9:0] pat;
    logic [7:0] got;
    int         idle_cnt;
    int         bad;
    bit         aborted;
    frame_t     f;
    idle_cnt = 0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        idle_cnt = 0;
      end else if (TX === 1'b1) begin
        idle_cnt++;
      end else begin
        mon_busy = 1'b1;
        aborted  = 1'b0;
        smp[0]   = TX;
        for (int i = 1; i < 10 * CPB; i++) begin
          @(negedge CLK);
          if (RESET) begin
            aborted = 1'b1;
            break;
          end
          smp[i] = TX;
        end
        if (!aborted) begin
          for (int b = 0; b < 8; b++)
            got[b] = smp[(b + 1) * CPB + CPB / 2];
          if (txq.size() == 0) begin
            check($sformatf("unexpected_frame_%h", got), 32'd1, 32'd0);
          end else begin
            f = txq.pop_front();
            check("frame_data", {24'd0, got}, {24'd0, f.data});
            pat = {1'b1, f.data, 1'b0};
            bad = 0;
            for (int i = 0; i < 10 * CPB; i++)
              if (smp[i] !== pat[i / CPB]) bad++;
            check($sformatf("frame_shape_%h", f.data), bad, 0);
            if (f.gap >= 0)
              check($sformatf("frame_gap_%h", f.data), idle_cnt, f.gap);
          end
        end
        idle_cnt = 0;
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    RESET       = 1'b1;
    bus.WRITE   = 1'b0;
    bus.READ    = 1'b0;
    bus.ADDRESS = '0;
    bus.DATA_IN = '0;
    idle(3);
    RESET = 1'b0;
    step();

    check("reset_tx", {31'd0, TX}, 32'd1);
    rd(STAT, 1'b1, 32'h2);

    // single frame, upper data bits ignored, one-cycle start latency
    expect_frame(8'h55, -1);
    wr(BASE, 32'hFFFF_FF55);
    check("tx_before_start", {31'd0, TX}, 32'd1);
    step();
    check("tx_start_bit", {31'd0, TX}, 32'd0);
    rd(STAT, 1'b1, 32'h6);
    idle(20);
    rd(STAT, 1'b1, 32'h6);
    wait_done(100);
    rd(STAT, 1'b1, 32'h2);

    // back-to-back frames
    expect_frame(8'h41, -1);
    expect_frame(8'h42, 1);
    expect_frame(8'h43, 1);
    wr_hold(BASE, 32'h41);
    wr_hold(BASE, 32'h42);
    wr(BASE, 32'h43);
    wait_done(200);
    rd(STAT, 1'b1, 32'h2);
    idle(5);

    // fill, overrun, sticky clear, and push accepted while full on a pop edge
    expect_frame(8'h10, -1);
    for (int b = 'h11; b <= 'h14; b++)
      expect_frame(8'(b), 1);
    expect_frame(8'h16, 1);
    for (int b = 'h10; b <= 'h14; b++)
      wr_hold(BASE, 32'(b));
    wr(BASE, 32'h15);
    rd(STAT, 1'b1, 32'hD);
    wr(STAT, 32'hFFFF_FFF7);
    rd(STAT, 1'b1, 32'hD);
    wr(STAT, 32'h8);
    rd(STAT, 1'b1, 32'h5);
    idle(31);
    wr(BASE, 32'h16);
    rd(STAT, 1'b1, 32'h5);
    wait_done(400);
    rd(STAT, 1'b1, 32'h2);

    // non-decoded addresses and TXDATA read
    wr(32'h0000_1008, 32'h77);
    wr(32'h0000_0000, 32'h88);
    wr(BASE + 32'd1, 32'h99);
    wr(32'h0000_1004 | 32'h8000_0000, 32'h08);
    rd(32'h0000_1008, 1'b0, 32'h0);
    rd(32'h0000_0000, 1'b0, 32'h0);
    rd(BASE, 1'b1, 32'h0);
    rd(STAT, 1'b1, 32'h2);
    idle(60);
    rd(STAT, 1'b1, 32'h2);

    // reset in the middle of data bit 4 with two bytes still queued
    wr_hold(BASE, 32'h61);
    wr_hold(BASE, 32'h62);
    wr(BASE, 32'h63);
    idle(20);
    check("tx_bit4_before_reset", {31'd0, TX}, 32'd0);
    RESET = 1'b1;
    #1;
    check("tx_async_reset", {31'd0, TX}, 32'd1);
    idle(2);
    RESET = 1'b0;
    step();
    rd(STAT, 1'b1, 32'h2);
    idle(150);
    check("no_frame_after_reset", {31'd0, mon_busy}, 32'd0);
    rd(STAT, 1'b1, 32'h2);
    idle(2);
    check("read_queue_drained", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the core's data-memory bus, alongside the data RAM. Decodes store and load cycles from the core (write/read strobes, address, store data). Store bytes are queued in a FIFO and serialised on `TX` as 8N1 frames. A status word is returned to the core's load-data mux, which lets firmware on the single-cycle core print to a host terminal.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, 16: TX FIFO entries. Power of two, ≥ 2.
- `BASE_ADDR`, 32'h0000_1000: TXDATA register address. STATUS is at `BASE_ADDR+4`.

Ports:
- `CLK`, in, 1: the single clock. All state changes on the rising edge.
- `RESET`, in, 1: asynchronous, active-high reset.
- `WRITE`, in, 1: store strobe from core, same signal that drives RAM.
- `READ`, in, 1: load strobe from core.
- `ADDRESS`, in, 32: full byte address from core (`DIR_DMEM`).
- `DATA_IN`, in, 32: store data from core.
- `DATA_OUT`, out, 32: load data for the core's read mux.
- `SEL`, out, 1: high when a load targets this block. The top uses it to select `DATA_OUT` over RAM.
- `TX`, out, 1: serial line, idle high.

## Operation
- Address decode uses full 32-bit equality. Word-aligned only. Other addresses are ignored.
- Write to TXDATA (`WRITE=1`, `ADDRESS=BASE_ADDR`):
  - `DATA_IN[7:0]` is pushed at the rising edge.
  - `DATA_IN[31:8]` is ignored.
  - If the FIFO is full and no pop happens in the same cycle, the byte is dropped and sticky `OVERRUN` is set.
- Write to STATUS: if `DATA_IN[3]=1`, `OVERRUN` is cleared. Other bits are ignored.
- STATUS read value, with bits [31:4] = 0:
  - bit0 `FULL`
  - bit1 `EMPTY`
  - bit2 `BUSY` (FSM not IDLE)
  - bit3 `OVERRUN`
- `SEL` = `READ && (ADDRESS==BASE_ADDR || ADDRESS==BASE_ADDR+4)`. Combinational.
- `DATA_OUT` is combinational:
  - STATUS when `READ && ADDRESS==BASE_ADDR+4`.
  - 0 for all other cases, including a read of TXDATA.
- FIFO:
  - Circular buffer. Read/write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
  - Occupancy count is `$clog2(FIFO_DEPTH)+1` bits.
  - Push and pop in the same cycle leave the count unchanged. This holds when full (push accepted) and when holding one entry.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - `TX=1`.
    - If the FIFO is not empty: pop the head into the shift register, clear the bit counter and baud counter, and go to START.
  - START: `TX=0` for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA:
    - `TX` = shift[0]. Shift right every `CLKS_PER_BIT` cycles.
    - After 8 bits (LSB first), go to STOP.
  - STOP: `TX=1` for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1. It wraps to 0 at each bit boundary.
- `TX` is registered (FSM-driven flop), so it has no glitches.

## Timing
- Reset values:
  - `TX=1`, state IDLE, FIFO empty (pointers 0, count 0), `OVERRUN=0`.
  - Hence STATUS reads 32'h0000_0002.
- `RESET` asserted mid-frame:
  - `TX` returns to 1 immediately (asynchronous).
  - The FIFO contents and the partial frame are discarded.
- Latency from a TXDATA write to the start bit, with the FIFO empty and FSM in IDLE:
  - Edge N: push.
  - Edge N+1: IDLE sees non-empty, pops, enters START.
  - `TX` falls after edge N+1.
- Frame duration: exactly `10*CLKS_PER_BIT` cycles, start edge to end of stop bit.
- Back-to-back frames have exactly one IDLE cycle (`TX=1`) between the end of a stop bit and the next start bit.
- STATUS reflects register state before the current edge. A load in the same cycle as a push does not see that push.
- A store to TXDATA holding `WRITE` for one cycle enqueues exactly one byte. Each cycle with `WRITE` high at TXDATA enqueues one byte.

## Test plan
- Reset, then read STATUS → `DATA_OUT`=32'h2, `SEL`=1, `TX`=1.
- `CLKS_PER_BIT`=4, write 32'hFFFF_FF55 to TXDATA → after one cycle, `TX` shows 0, 1,0,1,0,1,0,1,0, 1, each bit 4 cycles (40 cycles total). `BUSY`=1 throughout the frame, then STATUS=32'h2.
- Write 0x41, 0x42, 0x43 on consecutive cycles → three frames, LSB first, in order, with exactly one idle-high cycle between frames.
- `FIFO_DEPTH`=4, write 6 bytes on consecutive cycles while the first frame is sending → the first byte pops at cycle 2 so 5 are accepted (FULL=1) and the 6th is dropped with `OVERRUN`=1. Write 32'h8 to STATUS → `OVERRUN`=0.
- Write to 32'h0000_1008 and to RAM addresses, and read TXDATA → FIFO unchanged, `DATA_OUT`=0, `SEL`=0 for non-decoded addresses.
- Assert `RESET` at bit 4 of a frame with 2 bytes queued → `TX`=1 asynchronously, STATUS=32'h2 after release, and no further frames are sent.
